// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared constants, types and parameter check for the serial pattern detector
package seq_detect_pkg;

    localparam logic [3:0] DEF_PAT   = 4'b1001;
    localparam int         MAX_PAT_W = 16;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } det_state_e;

    function automatic bit pat_w_ok(input int w);
        return (w >= 2) && (w <= MAX_PAT_W);
    endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// rtl/seq_hist_shreg.sv - enabled shift register with sync clear, newest sample in the LSB
module seq_hist_shreg #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] shifted;

    // A one-bit history simply takes the new sample.
    if (W == 1) begin : g_w1
        assign shifted = d_i;
    end else begin : g_wn
        assign shifted = {q_q[W-2:0], d_i};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else if (clr_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= shifted;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - runtime-loadable serial pattern detector with Mealy/Moore flags and match counter
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_PAT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] count
);

    if (!pat_w_ok(PAT_W)) begin : g_bad_pat_w
        $error("seq_detect_param: PAT_W must be within 2..16");
    end

    localparam int               FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-2:0]  hist_q;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              y_q_q;
    logic              sample;
    logic              match;
    det_state_e        state;

    seq_hist_shreg #(
        .W (PAT_W - 1)
    ) u_hist (
        .clk   (clk),
        .reset (reset),
        .en_i  (sample),
        .clr_i (load),
        .d_i   (x),
        .q_o   (hist_q)
    );

    // The FSM state is a view of the fill counter, not a register of its own.
    assign state  = (fill_q == FILL_FULL) ? ST_ARMED : ST_FILL;
    assign sample = valid & ~load;
    assign match  = sample && (state == ST_ARMED) && ({hist_q, x} == pat_q);

    always_comb begin
        pat_d   = pat_q;
        fill_d  = fill_q;
        count_d = count_q;
        if (load) begin
            pat_d   = pat_in;
            fill_d  = '0;
            count_d = '0;
        end else if (valid) begin
            case (state)
                ST_FILL:  fill_d = fill_q + 1'b1;
                ST_ARMED: if (match && !overlap) fill_d = '0;
                default:  fill_d = '0;
            endcase
            if (match && (count_q != CNT_MAX)) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q   <= RST_PAT;
            fill_q  <= '0;
            count_q <= '0;
            y_q_q   <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            y_q_q   <= match;
        end
    end

    assign y     = match;
    assign y_q   = y_q_q;
    assign count = count_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed and randomized checks of seq_detect_param against a sample-queue model
module tb_seq_detect_param;

    localparam int P = 4;
    localparam int C = 2;
    localparam int CMAX = (1 << C) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         x;
    logic         valid;
    logic         load;
    logic [P-1:0] pat_in;
    logic         overlap;
    logic         y;
    logic         y_q;
    logic [C-1:0] count;

    int n_chk = 0;
    int n_err = 0;

    logic [P-1:0] pat_m;
    bit           mq[$];
    int           cnt_m;

    seq_detect_param #(
        .PAT_W (P),
        .CNT_W (C)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .x       (x),
        .valid   (valid),
        .load    (load),
        .pat_in  (pat_in),
        .overlap (overlap),
        .y       (y),
        .y_q     (y_q),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        pat_m = 4'b1001;
        mq.delete();
        cnt_m = 0;
    endfunction

    // Match needs PAT_W-1 samples since the last clear plus the current bit, all equal to the pattern.
    function automatic bit model_y(input bit xv, input bit vv, input bit lv);
        if (!vv || lv || mq.size() != P - 1) return 1'b0;
        for (int i = 0; i < P - 1; i++) begin
            if (mq[i] != pat_m[P-1-i]) return 1'b0;
        end
        return xv == pat_m[0];
    endfunction

    function automatic void model_clock(input bit xv, input bit vv, input bit lv,
                                        input logic [P-1:0] pv, input bit ov, input bit hit);
        if (lv) begin
            pat_m = pv;
            mq.delete();
            cnt_m = 0;
        end else if (vv) begin
            if (hit && cnt_m < CMAX) cnt_m++;
            if (hit && !ov) begin
                mq.delete();
            end else begin
                mq.push_back(xv);
                if (mq.size() > P - 1) void'(mq.pop_front());
            end
        end
    endfunction

    // Starts and ends one time unit after a rising edge.
    task automatic step(input bit xv, input bit vv, input bit lv, input logic [P-1:0] pv,
                        input bit ov, output bit got_y);
        bit ey;
        x = xv; valid = vv; load = lv; pat_in = pv; overlap = ov;
        #2;
        ey    = model_y(xv, vv, lv);
        got_y = y;
        check("y", y, ey);
        @(posedge clk);
        #1;
        model_clock(xv, vv, lv, pv, ov, ey);
        check("y_q", y_q, ey);
        check("count", count, cnt_m);
    endtask

    task automatic send(input bit xv, input bit ov, output bit got_y);
        step(xv, 1'b1, 1'b0, '0, ov, got_y);
    endtask

    task automatic do_load(input logic [P-1:0] pv);
        bit gy;
        step(1'b0, 1'b0, 1'b1, pv, 1'b0, gy);
    endtask

    task automatic run_stream7(input bit ov, input logic [6:0] exp_mask, input int exp_cnt);
        bit s[7] = '{1, 0, 0, 1, 0, 0, 1};
        logic [6:0] m;
        bit gy;
        for (int i = 0; i < 7; i++) begin
            send(s[i], ov, gy);
            m[i] = gy;
        end
        check(ov ? "ovl_mask" : "novl_mask", m, exp_mask);
        check(ov ? "ovl_count" : "novl_count", count, exp_cnt);
    endtask

    initial begin
        bit gy;
        logic [4:0] m5;
        reset = 1'b0; x = 1'b0; valid = 1'b0; load = 1'b0; pat_in = '0; overlap = 1'b0;
        model_reset();
        #1;
        check("rst_y", y, 0);
        check("rst_y_q", y_q, 0);
        check("rst_count", count, 0);
        repeat (2) @(posedge clk);
        #4 reset = 1'b1;
        @(posedge clk);
        #1;

        run_stream7(1'b1, 7'b1001000, 2);
        do_load(4'b1001);
        run_stream7(1'b0, 7'b0001000, 1);

        do_load(4'b1001);
        send(1'b1, 1'b1, gy);
        send(1'b0, 1'b1, gy);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, 1'b1, gy);
            check("gap_y", gy, 0);
        end
        send(1'b0, 1'b1, gy);
        send(1'b1, 1'b1, gy);
        check("gap_final_y", gy, 1);

        send(1'b1, 1'b1, gy);
        send(1'b0, 1'b1, gy);
        send(1'b0, 1'b1, gy);
        do_load(4'b1111);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b1, gy);
            m5[i] = gy;
        end
        check("load_mask", m5, 5'b11000);
        check("load_count", count, 2);

        do_load(4'b1111);
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 1'b1, gy);
            if (i >= 3) check("sat_y", gy, 1);
        end
        check("sat_count", count, 3);

        do_load(4'b1001);
        send(1'b1, 1'b1, gy);
        send(1'b0, 1'b1, gy);
        send(1'b0, 1'b1, gy);
        valid = 1'b0; load = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("mid_rst_count", count, 0);
        check("mid_rst_y_q", y_q, 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        send(1'b1, 1'b1, gy);
        check("post_rst_y", gy, 0);
        check("post_rst_count", count, 0);
        send(1'b1, 1'b1, gy);
        send(1'b0, 1'b1, gy);
        send(1'b0, 1'b1, gy);
        send(1'b1, 1'b1, gy);
        check("post_rst_match", gy, 1);

        for (int i = 0; i < 3000; i++) begin
            bit rl;
            rl = ($urandom_range(0, 39) == 0);
            step($urandom_range(0, 1), $urandom_range(0, 3) != 0, rl,
                 P'($urandom_range(0, (1 << P) - 1)), $urandom_range(0, 1), gy);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
